flash_audio_sequencer: RTL and testbench

Plays back audio stored in on-board flash under keyboard control. It sits between the keyboard command FSM (`direction`, `pause`, `restart` levels) and the flash memory's Avalon-MM read master port. It fetches 32-bit words, splits each into two 16-bit samples, and steps the word address up or down with wrap-around. It presents one sample per `sample_tick` to the audio output path.

---
 rtl/flash_audio_pkg.sv | 18 +
 rtl/flash_addr_counter.sv | 31 +++
 rtl/flash_audio_sequencer.sv | 147 ++++++++++++++
 tb/tb_flash_audio_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio playback path.
// Holds the sequencer state encoding and direction levels.
package flash_audio_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_FETCH,
    S_WAIT,
    S_PLAY0,
    S_PLAY1
  } seq_state_t;

  localparam logic FWD = 1'b1;
  localparam logic BWD = 1'b0;

  localparam logic [22:0] DEFAULT_MAX_ADDR = 23'h7FFFF;

endpackage

// File: rtl/flash_addr_counter.sv
// Up/down wrapping word-address counter for the audio clip.
// Loads the clip start (0 or MAX_ADDR) and wraps at both ends.
module flash_addr_counter
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEFAULT_MAX_ADDR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              load_fwd,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= (load_fwd == FWD) ? '0 : MAX_ADDR;
    end else if (step) begin
      if (dir == FWD)
        addr <= (addr == MAX_ADDR) ? '0 : addr + ADDR_W'(1);
      else
        addr <= (addr == '0) ? MAX_ADDR : addr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit audio words from flash and plays them out as
// two 16-bit samples per word, one per accepted sample tick.
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEFAULT_MAX_ADDR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              direction,
  input  logic              pause,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              sample_valid,
  output logic              underrun
);

  seq_state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              word_dir;
  logic              restart_pend;

  logic tick_ok;
  logic load, step, accept, latch;
  logic emit, emit_hi;
  logic set_pend, clr_pend;
  logic set_under, clr_under;

  assign tick_ok       = sample_tick & ~pause;
  assign flash_address = addr;

  flash_addr_counter #(
    .ADDR_W  (ADDR_W),
    .MAX_ADDR(MAX_ADDR)
  ) u_addr (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .load_fwd(direction),
    .step    (step),
    .dir     (direction),
    .addr    (addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_HOLD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    flash_read = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    accept     = 1'b0;
    latch      = 1'b0;
    emit       = 1'b0;
    emit_hi    = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    set_under  = 1'b0;
    clr_under  = 1'b0;
    unique case (state)
      S_HOLD: begin
        load      = 1'b1;
        clr_pend  = 1'b1;
        clr_under = 1'b1;
        if (!restart) state_nx = S_FETCH;
      end
      S_FETCH: begin
        flash_read = 1'b1;
        set_under  = tick_ok & ~restart;
        if (!flash_waitrequest) begin
          // An accepted request must complete; restart waits for its data.
          accept   = 1'b1;
          set_pend = restart;
          state_nx = S_WAIT;
        end else if (restart) begin
          state_nx = S_HOLD;
        end
      end
      S_WAIT: begin
        set_pend  = restart;
        set_under = tick_ok & ~restart;
        if (flash_readdatavalid) begin
          if (restart_pend || restart) begin
            state_nx = S_HOLD;
          end else begin
            latch    = 1'b1;
            state_nx = S_PLAY0;
          end
        end
      end
      S_PLAY0: begin
        if (restart) begin
          state_nx = S_HOLD;
        end else if (tick_ok) begin
          emit     = 1'b1;
          emit_hi  = (word_dir == BWD);
          state_nx = S_PLAY1;
        end
      end
      S_PLAY1: begin
        if (restart) begin
          state_nx = S_HOLD;
        end else if (tick_ok) begin
          emit     = 1'b1;
          emit_hi  = (word_dir == FWD);
          step     = 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_HOLD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word         <= '0;
      word_dir     <= FWD;
      restart_pend <= 1'b0;
      audio_sample <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= emit;
      if (accept) word_dir <= direction;
      if (latch)  word     <= flash_readdata;
      if (emit)
        audio_sample <= emit_hi ? word[31:16] : word[15:0];
      if (clr_pend)      restart_pend <= 1'b0;
      else if (set_pend) restart_pend <= 1'b1;
      if (clr_under)      underrun <= 1'b0;
      else if (set_under) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Scoreboard bench: random words, ticks and pauses against a
// clip-level playback model, plus restart, underrun and reset cases.
module tb_flash_audio_sequencer;

  localparam int NW = 4;
  localparam logic [22:0] MAXA = 23'd3;

  logic        clock;
  logic        reset;
  logic        direction;
  logic        pause;
  logic        restart;
  logic        sample_tick;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        underrun;

  flash_audio_sequencer #(
    .ADDR_W  (23),
    .MAX_ADDR(MAXA)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .direction          (direction),
    .pause              (pause),
    .restart            (restart),
    .sample_tick        (sample_tick),
    .flash_read         (flash_read),
    .flash_address      (flash_address),
    .flash_waitrequest  (flash_waitrequest),
    .flash_readdata     (flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .audio_sample       (audio_sample),
    .sample_valid       (sample_valid),
    .underrun           (underrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [NW];
  logic [15:0] exp_q [$];
  int force_ws  = -1;
  int force_lat = -1;
  int acc_cnt   = 0;
  bit model_dir = 1'b1;
  int fetch_k   = 0;
  int tick_t    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // k-th word of the clip in the current playback direction
  function automatic int waddr(input int k);
    return model_dir ? (k % NW) : (NW - 1 - (k % NW));
  endfunction

  function automatic logic [15:0] wsample(input int t);
    logic [31:0] w;
    bit lo;
    w  = mem[waddr(t / 2)];
    lo = ((t % 2) == 0) == model_dir;
    return lo ? w[15:0] : w[31:16];
  endfunction

  // Avalon slave: decisions made at negedge, seen by DUT at posedge
  initial begin
    int ws_left;
    int lat_left;
    logic [22:0] a_pend;
    ws_left  = -1;
    lat_left = -1;
    a_pend   = '0;
    flash_waitrequest   = 1'b1;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ws_left  = -1;
        lat_left = -1;
        flash_waitrequest   = 1'b1;
        flash_readdatavalid = 1'b0;
        continue;
      end
      flash_readdatavalid = 1'b0;
      if (lat_left == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = mem[a_pend[1:0]];
        lat_left            = -1;
      end else if (lat_left > 0) begin
        lat_left--;
      end
      if (flash_read) begin
        if (ws_left < 0)
          ws_left = (force_ws >= 0) ? force_ws : int'($urandom_range(0, 3));
        if (ws_left == 0) begin
          flash_waitrequest = 1'b0;
          a_pend   = flash_address;
          lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
          ws_left  = -1;
          acc_cnt++;
          chk("fetch_addr", 32'(flash_address), 32'(waddr(fetch_k)));
          fetch_k++;
        end else begin
          flash_waitrequest = 1'b1;
          ws_left--;
        end
      end else begin
        flash_waitrequest = 1'b1;
        ws_left = -1;
      end
    end
  end

  // Monitor: every sample_valid pulse must match the next expected sample
  initial begin
    forever begin
      @(negedge clock);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_sample: got %0h expected none", audio_sample);
        end else begin
          chk("sample", 32'(audio_sample), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input bit p, input bit counted);
    @(negedge clock);
    sample_tick = 1'b1;
    pause       = p;
    if (!p && counted) begin
      exp_q.push_back(wsample(tick_t));
      tick_t++;
    end
    @(negedge clock);
    sample_tick = 1'b0;
    pause       = 1'b0;
  endtask

  task automatic hold_restart(input bit d);
    @(negedge clock);
    restart   = 1'b1;
    direction = d;
    repeat (14) @(negedge clock);
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    model_dir = d;
    fetch_k   = 0;
    tick_t    = 0;
  endtask

  task automatic wait_accept(input string name, input int base);
    int n;
    n = 0;
    while (acc_cnt <= base && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(acc_cnt > base), 32'd1);
  endtask

  task automatic phase(input bit d, input int nticks);
    hold_restart(d);
    restart = 1'b0;
    repeat (20) @(negedge clock);
    for (int i = 0; i < nticks; i++) begin
      tick($urandom_range(0, 3) == 0, 1'b1);
      repeat (38) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("no_underrun", 32'(underrun), 32'd0);
  endtask

  initial begin
    int a0;
    reset       = 1'b1;
    restart     = 1'b1;
    direction   = 1'b1;
    pause       = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    chk("rst_read", 32'(flash_read), 32'd0);
    chk("rst_addr", 32'(flash_address), 32'd0);
    chk("rst_sample", 32'(audio_sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;

    phase(1'b1, 20);
    phase(1'b0, 20);

    // restart while waiting for read data: word discarded, refetch at 0
    hold_restart(1'b1);
    force_ws  = 3;
    force_lat = 5;
    a0 = acc_cnt;
    restart = 1'b0;
    wait_accept("first_accept", a0);
    @(negedge clock);
    restart = 1'b1;
    fetch_k = 0;
    tick_t  = 0;
    @(negedge clock);
    restart = 1'b0;
    a0 = acc_cnt;
    wait_accept("refetch_after_restart", a0);
    repeat (20) @(negedge clock);
    tick(1'b0, 1'b1);
    repeat (38) @(negedge clock);

    // underrun: tick while the next word is still in flight
    force_ws  = 0;
    force_lat = 10;
    tick(1'b0, 1'b1);
    @(negedge clock);
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    chk("underrun_set", 32'(underrun), 32'd1);
    repeat (15) @(negedge clock);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    chk("underrun_queue", 32'(exp_q.size()), 32'd0);
    restart = 1'b1;
    repeat (14) @(negedge clock);
    chk("underrun_cleared", 32'(underrun), 32'd0);

    // async reset while a backward fetch is stalled
    force_ws  = 8;
    force_lat = -1;
    hold_restart(1'b0);
    restart = 1'b0;
    repeat (3) @(negedge clock);
    chk("fetch_pending", 32'(flash_read), 32'd1);
    chk("fetch_addr_bwd", 32'(flash_address), 32'(MAXA));
    restart = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("arst_read", 32'(flash_read), 32'd0);
    chk("arst_addr", 32'(flash_address), 32'd0);
    chk("arst_sample", 32'(audio_sample), 32'd0);
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    @(negedge clock);
    reset    = 1'b0;
    force_ws = -1;

    phase(1'b0, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
